// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master controller driving an external 8-bit shift register.
// Half-period h = max(clk_div,2)+1 cycles; miso is double-synchronised before sampling.
module spi_master_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic [7:0] clk_div,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       shr_ld,
  output logic [7:0] shr_ld_data,
  output logic       shr_sh,
  output logic       shr_din,
  input  logic       shr_dout,
  input  logic [7:0] shr_dstr,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, HIGH, LOW, TRAIL, DONE} state_t;

  state_t     state;
  logic [7:0] hm1;      // h-1, latched at start
  logic [7:0] cnt;
  logic [7:0] tx_lat;
  logic [2:0] bit_cnt;
  logic [1:0] sync;
  logic       sample;

  assign shr_ld_data = tx_lat;
  assign shr_din     = sample;
  assign mosi        = ~ss_n & shr_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hm1     <= 8'd2;
      cnt     <= 8'd0;
      tx_lat  <= 8'd0;
      bit_cnt <= 3'd0;
      sync    <= 2'b00;
      sample  <= 1'b0;
      sck     <= 1'b0;
      ss_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      shr_ld  <= 1'b0;
      shr_sh  <= 1'b0;
      rx_data <= 8'd0;
    end else begin
      sync <= {sync[0], miso};
      case (state)
        IDLE: begin
          if (start) begin
            tx_lat <= tx_data;
            hm1    <= (clk_div < 8'd2) ? 8'd2 : clk_div;
            shr_ld <= 1'b1;
            ss_n   <= 1'b0;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          shr_ld <= 1'b0;
          cnt    <= hm1;
          state  <= LEAD;
        end
        LEAD, LOW: begin
          if (cnt == 8'd0) begin
            sck    <= 1'b1;
            sample <= sync[1];
            cnt    <= hm1;
            state  <= HIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HIGH: begin
          // Shift pulse occupies the last HIGH cycle so the register moves on the sck fall.
          shr_sh <= (cnt == 8'd1) && (bit_cnt != 3'd7);
          if (cnt == 8'd0) begin
            sck <= 1'b0;
            cnt <= hm1;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              state   <= LOW;
            end else begin
              rx_data <= shr_dstr;
              state   <= TRAIL;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TRAIL: begin
          if (cnt == 8'd0) begin
            done  <= 1'b1;
            ss_n  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= 3'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: models the shift register and an SPI slave, checks
// each transfer against byte/timing expectations derived from the transfer rules.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, shr_ld, shr_sh, shr_din, shr_dout;
  logic       sck, mosi, miso, ss_n;
  logic [7:0] tx_data, clk_div, rx_data, shr_ld_data, shr_dstr;

  always #5 clk = ~clk;

  spi_master_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .clk_div(clk_div),
    .busy(busy), .done(done), .rx_data(rx_data),
    .shr_ld(shr_ld), .shr_ld_data(shr_ld_data), .shr_sh(shr_sh), .shr_din(shr_din),
    .shr_dout(shr_dout), .shr_dstr(shr_dstr),
    .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  // External shift register
  logic [7:0] shreg = 8'd0;
  assign shr_dout = shreg[7];
  assign shr_dstr = {shreg[6:0], shr_din};
  always @(posedge clk) begin
    if (shr_ld) shreg <= shr_ld_data;
    else if (shr_sh) shreg <= shr_dstr;
  end

  // Slave: presents MSB on select, next bit after each sck fall
  logic [7:0] slave_byte = 8'd0;
  logic       loopback = 1'b0;
  int         sfall = 0;
  logic       slave_miso;
  always @(negedge sck or posedge ss_n) begin
    if (ss_n) sfall = 0;
    else sfall = sfall + 1;
  end
  assign slave_miso = (sfall < 8) ? slave_byte[3'(7 - sfall)] : 1'b0;
  assign miso = loopback ? mosi : slave_miso;

  // Monitor: monotonic event counters plus per-transfer rise capture
  int         exp_h = 3;
  int         cyc = 0, rise_total = 0, xfer_rise = 0, last_rise = 0;
  int         busy_n = 0, done_n = 0, ld_n = 0, sh_n = 0, both_n = 0, mosi_err = 0, per_err = 0;
  int         gap_run = 0, last_gap = 0;
  logic [7:0] mosi_bits = 8'd0;
  logic       sck_prev = 1'b0, ssn_prev = 1'b1;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!ss_n && ssn_prev) begin
      xfer_rise = 0;
      last_gap  = gap_run;
    end
    if (sck && !sck_prev) begin
      if (xfer_rise < 8) mosi_bits[3'(7 - xfer_rise)] = mosi;
      if (xfer_rise > 0 && (cyc - last_rise) != 2 * exp_h) per_err = per_err + 1;
      last_rise  = cyc;
      xfer_rise  = xfer_rise + 1;
      rise_total = rise_total + 1;
    end
    if (busy) busy_n = busy_n + 1;
    if (done) done_n = done_n + 1;
    if (shr_ld) ld_n = ld_n + 1;
    if (shr_sh) sh_n = sh_n + 1;
    if (shr_ld && shr_sh) both_n = both_n + 1;
    if (mosi !== (ss_n ? 1'b0 : shr_dout)) mosi_err = mosi_err + 1;
    gap_run  = ss_n ? gap_run + 1 : 0;
    sck_prev = sck;
    ssn_prev = ss_n;
  end

  int checks = 0, passes = 0;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks += 8;
    if (sck !== 1'b0) $display("FAIL reset_sck got %b want 0", sck); else passes++;
    if (ss_n !== 1'b1) $display("FAIL reset_ss_n got %b want 1", ss_n); else passes++;
    if (mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi); else passes++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    if (shr_ld !== 1'b0) $display("FAIL reset_shr_ld got %b want 0", shr_ld); else passes++;
    if (shr_sh !== 1'b0) $display("FAIL reset_shr_sh got %b want 0", shr_sh); else passes++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else passes++;
    rst = 1'b0;
    $display("reset: sck=%b ss_n=%b busy=%b rx=%h", sck, ss_n, busy, rx_data);
  endtask

  // One transfer; extra_at >= 0 re-pulses start mid-transfer, at_done re-pulses it during done.
  task automatic run_transfer(input string name, input logic [7:0] tx, input logic [7:0] div,
                              input logic [7:0] sbyte, input logic lb, input int extra_at,
                              input logic at_done, input int tail);
    int h, t, b0, d0, l0, s0, bo0, me0, pe0, r0;
    logic saw_done;
    logic [7:0] exp_rx;
    h = ((div < 8'd2) ? 2 : int'(div)) + 1;
    exp_rx = lb ? tx : sbyte;
    @(negedge clk);
    #1;
    exp_h = h; slave_byte = sbyte; loopback = lb;
    b0 = busy_n; d0 = done_n; l0 = ld_n; s0 = sh_n; bo0 = both_n; me0 = mosi_err;
    pe0 = per_err; r0 = rise_total;
    start = 1'b1; tx_data = tx; clk_div = div;
    @(negedge clk);
    #1;
    start = 1'b0; tx_data = ~tx; clk_div = 8'd7;
    t = 0; saw_done = 1'b0;
    while (t < 4000 && !(saw_done && !busy)) begin
      if (done) saw_done = 1'b1;
      start = (t == extra_at) || (at_done && done);
      @(negedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    checks++;
    if (t >= 4000) $display("FAIL %s_timeout waited %0d cycles, done never completed", name, t);
    else passes++;
    repeat (tail) @(negedge clk);
    #1;
    checks += 10;
    if (mosi_bits !== tx) $display("FAIL %s_mosi_bits got %h want %h", name, mosi_bits, tx); else passes++;
    if (rx_data !== exp_rx) $display("FAIL %s_rx_data got %h want %h", name, rx_data, exp_rx); else passes++;
    if (rise_total - r0 != 8) $display("FAIL %s_sck_rises got %0d want 8", name, rise_total - r0); else passes++;
    if (per_err - pe0 != 0) $display("FAIL %s_sck_period bad periods %0d want 0 (period %0d)", name, per_err - pe0, 2 * h); else passes++;
    if (busy_n - b0 != 17 * h + 2) $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_n - b0, 17 * h + 2); else passes++;
    if (done_n - d0 != 1) $display("FAIL %s_done_pulses got %0d want 1", name, done_n - d0); else passes++;
    if (ld_n - l0 != 1) $display("FAIL %s_ld_pulses got %0d want 1", name, ld_n - l0); else passes++;
    if (sh_n - s0 != 7) $display("FAIL %s_sh_pulses got %0d want 7", name, sh_n - s0); else passes++;
    if (both_n - bo0 != 0) $display("FAIL %s_ld_sh_overlap got %0d cycles want 0", name, both_n - bo0); else passes++;
    if (mosi_err - me0 != 0) $display("FAIL %s_mosi_follow got %0d bad cycles want 0", name, mosi_err - me0); else passes++;
    $display("%s: tx=%h div=%0d h=%0d rx=%h busy=%0d done=%0d", name, tx, div, h, rx_data, busy_n - b0, done_n - d0);
  endtask

  task automatic test_basic();
    run_transfer("basic", 8'hA5, 8'd2, 8'h3C, 1'b0, -1, 1'b0, 4);
  endtask

  task automatic test_div0();
    run_transfer("div0", 8'h96, 8'd0, 8'h81, 1'b0, -1, 1'b0, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_transfer("random", 8'($urandom), 8'($urandom_range(0, 5)), 8'($urandom), 1'b0, -1, 1'b0, 2);
  endtask

  task automatic test_ignore_start();
    run_transfer("ignore", 8'h5A, 8'd3, 8'hC3, 1'b0, 20, 1'b1, 6);
  endtask

  task automatic test_reset_mid();
    int t, d0, r0;
    @(negedge clk);
    #1;
    exp_h = 3; slave_byte = 8'hE7; loopback = 1'b0;
    d0 = done_n; r0 = rise_total;
    start = 1'b1; tx_data = 8'h4B; clk_div = 8'd2;
    @(negedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (t < 500 && rise_total - r0 < 4) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 500) $display("FAIL rstmid_timeout no 4th sck rise within %0d cycles", t); else passes++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks += 4;
    if (ss_n !== 1'b1) $display("FAIL rstmid_ss_n got %b want 1", ss_n); else passes++;
    if (sck !== 1'b0) $display("FAIL rstmid_sck got %b want 0", sck); else passes++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passes++;
    if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data got %h want 00", rx_data); else passes++;
    rst = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    checks += 2;
    if (done_n - d0 != 0) $display("FAIL rstmid_done got %0d pulses want 0", done_n - d0); else passes++;
    if (busy !== 1'b0) $display("FAIL rstmid_idle_busy got %b want 0", busy); else passes++;
    $display("reset_mid: ss_n=%b sck=%b busy=%b rx=%h done=%0d", ss_n, sck, busy, rx_data, done_n - d0);
  endtask

  task automatic test_back_to_back();
    run_transfer("b2b_ff", 8'hFF, 8'd2, 8'h00, 1'b1, -1, 1'b0, 0);
    run_transfer("b2b_00", 8'h00, 8'd2, 8'hFF, 1'b1, -1, 1'b0, 2);
    checks++;
    if (last_gap < 1) $display("FAIL b2b_ss_n_gap got %0d cycles want >=1", last_gap); else passes++;
    $display("back_to_back: ss_n high gap=%0d", last_gap);
    loopback = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_data = 8'h00; clk_div = 8'h00;
    test_reset();
    test_basic();
    test_div0();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
